wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 75 +++++++
 tb/tb_wb_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-port writeback arbiter with ALU starvation guard and pending-write scoreboard
module wb_arbiter #(
    parameter int STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        busy1,
    output logic        busy2,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
);
    localparam int SW = STARVE_LIMIT < 1 ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
    logic [SW-1:0] starve_cnt;
    logic [31:0]   busy, busy_nx;
    logic          alu_pri, xfer;
    logic [4:0]    wr_rd;
    logic [31:0]   wr_data;
    // Grant: LSU wins ties unless the ALU has lost STARVE_LIMIT times in a row
    always_comb begin
        alu_pri   = starve_cnt == LIM;
        alu_ready = rst_n && alu_valid && (!lsu_valid || alu_pri);
        lsu_ready = rst_n && lsu_valid && !alu_ready;
        xfer      = alu_ready || lsu_ready;
        wr_rd     = alu_ready ? alu_rd : lsu_rd;
        wr_data   = alu_ready ? alu_data : lsu_data;
    end
    // Count consecutive ALU losses, saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_cnt <= '0;
        else if (alu_valid && !alu_ready) starve_cnt <= alu_pri ? LIM : starve_cnt + 1'b1;
        else starve_cnt <= '0;
    end
    // Register the granted write; writes to x0 are consumed but not committed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= xfer && wr_rd != 5'd0;
            if (xfer && wr_rd != 5'd0) begin
                rf_wa <= wr_rd;
                rf_wd <= wr_data;
            end
        end
    end
    // Next scoreboard state: commit clears, issue sets, set wins on collision
    always_comb begin
        busy_nx = busy;
        if (rf_we) busy_nx[rf_wa] = 1'b0;
        if (iss_valid) busy_nx[iss_rd] = 1'b1;
        busy_nx[0] = 1'b0;
    end
    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else busy <= busy_nx;
    end
    assign busy1 = busy[ra1];
    assign busy2 = busy[ra2];
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table vectors plus hand sequences, write results checked through a scoreboard queue
module tb_wb_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        alu_valid = 1'b0, lsu_valid = 1'b0, iss_valid = 1'b0;
    logic [4:0]  alu_rd = '0, lsu_rd = '0, iss_rd = '0, ra1 = '0, ra2 = '0;
    logic [31:0] alu_data = '0, lsu_data = '0;
    logic        alu_ready, lsu_ready, busy1, busy2, rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    wb_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .ra1(ra1), .ra2(ra2),
        .busy1(busy1), .busy2(busy2), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        exp_ar;
        logic        exp_lr;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        bit          chk_data;
    } wr_t;

    wr_t         sb[$];
    int          n_chk = 0, n_fail = 0;
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0;
    bit          hold_ok = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, check grants, queue expected write, then compare after the edge
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic iv, input logic [4:0] ird,
                         input logic exp_ar, input logic exp_lr);
        wr_t e, g;
        @(negedge clk);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        iss_valid = iv; iss_rd = ird;
        #1;
        chk("alu_ready", 32'(alu_ready), 32'(exp_ar));
        chk("lsu_ready", 32'(lsu_ready), 32'(exp_lr));
        if (exp_ar || exp_lr) begin
            e.wa = exp_ar ? ard : lrd;
            e.wd = exp_ar ? ad : ld;
            e.we = e.wa != 5'd0;
        end else begin
            e.we = 1'b0;
        end
        if (e.we) begin
            m_wa = e.wa; m_wd = e.wd; hold_ok = 1'b1;
        end else begin
            if (exp_ar || exp_lr) hold_ok = 1'b0;
            e.wa = m_wa; e.wd = m_wd;
        end
        e.chk_data = e.we || hold_ok;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard: queue empty, expected one entry");
        end else begin
            g = sb.pop_front();
            chk("rf_we", 32'(rf_we), 32'(g.we));
            if (g.chk_data) begin
                chk("rf_wa", 32'(rf_wa), 32'(g.wa));
                chk("rf_wd", rf_wd, g.wd);
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'd0,        1'b1, 1'b0};
        vecs[1] = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd6,  32'hCAFEF00D, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 5'd2,  32'h11,       1'b0, 5'd2,  32'h22,       1'b0, 1'b0};
        vecs[3] = '{1'b1, 5'd4,  32'h44,       1'b1, 5'd3,  32'h33,       1'b0, 1'b1};
        vecs[4] = '{1'b0, 5'd0,  32'd0,        1'b1, 5'd0,  32'h1234,     1'b0, 1'b1};
        vecs[5] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'd0,        1'b1, 1'b0};

        // reset state, with both producers asserting valid
        alu_valid = 1'b1; lsu_valid = 1'b1; ra1 = 5'd7; ra2 = 5'd9;
        #12;
        chk("reset alu_ready", 32'(alu_ready), 32'd0);
        chk("reset lsu_ready", 32'(lsu_ready), 32'd0);
        chk("reset rf_we", 32'(rf_we), 32'd0);
        chk("reset rf_wa", 32'(rf_wa), 32'd0);
        chk("reset rf_wd", rf_wd, 32'd0);
        chk("reset busy1", 32'(busy1), 32'd0);
        @(negedge clk);
        alu_valid = 1'b0; lsu_valid = 1'b0; rst_n = 1'b1;

        // table vectors, each from an idle starve state
        for (int i = 0; i < 6; i++) begin
            cycle(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld,
                  1'b0, 5'd0, vecs[i].exp_ar, vecs[i].exp_lr);
            idle();
        end

        // both valid for 4 cycles: LSU, LSU, ALU, LSU
        cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 1'b1);
        chk("starve after 1", 32'(dut.starve_cnt), 32'd1);
        cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 1'b1);
        chk("starve after 2", 32'(dut.starve_cnt), 32'd2);
        cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b1, 1'b0);
        chk("starve after alu grant", 32'(dut.starve_cnt), 32'd0);
        cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 1'b0, 1'b1);
        idle();
        chk("starve cleared idle", 32'(dut.starve_cnt), 32'd0);

        // issue r7, busy until the write to r7 commits
        ra1 = 5'd7;
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 1'b0);
        chk("busy1 r7 set", 32'(busy1), 32'd1);
        cycle(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        chk("busy1 r7 at commit edge", 32'(busy1), 32'd1);
        idle();
        chk("busy1 r7 cleared", 32'(busy1), 32'd0);

        // issue r9 on the same edge a write to r9 commits: set wins
        ra2 = 5'd9;
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 1'b0, 1'b1);
        chk("busy2 r9 before", 32'(busy2), 32'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 1'b0);
        chk("busy2 r9 set wins", 32'(busy2), 32'd1);
        idle();
        chk("busy2 r9 held", 32'(busy2), 32'd1);

        // x0 never becomes busy
        ra1 = 5'd0;
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        chk("busy1 r0", 32'(busy1), 32'd0);

        // reset pulsed the cycle after an acceptance, with r12 busy
        ra1 = 5'd12;
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 1'b0);
        chk("busy1 r12 set", 32'(busy1), 32'd1);
        @(negedge clk);
        iss_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
        #1;
        chk("pre-reset alu_ready", 32'(alu_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("pre-reset rf_we", 32'(rf_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid reset rf_we", 32'(rf_we), 32'd0);
        chk("mid reset rf_wa", 32'(rf_wa), 32'd0);
        chk("mid reset rf_wd", rf_wd, 32'd0);
        chk("mid reset busy1", 32'(busy1), 32'd0);
        chk("mid reset busy2", 32'(busy2), 32'd0);
        chk("mid reset alu_ready", 32'(alu_ready), 32'd0);
        chk("mid reset starve", 32'(dut.starve_cnt), 32'd0);
        @(negedge clk);
        alu_valid = 1'b0; rst_n = 1'b1;
        m_wa = '0; m_wd = '0; hold_ok = 1'b1;
        idle();
        cycle(1'b1, 5'd10, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
